lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store port between the execute/commit stages and the data `Memory` block. It accepts one load or store request at a time over a valid/ready handshake. It drives `Memory`'s read/write ports and synthesises SB/SH as read-modify-write, because `Memory` writes whole words only. Each access returns one tagged response to the ROB/writeback side.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `DEPTH`, 1024, words in `Memory`
- `ROB_TAG_WIDTH`, 5, response tag width

Ports:
- `clk` in 1, single clock; everything on posedge
- `rst` in 1, synchronous, active-high
- `flush` in 1, kills in-flight load
- `req_valid` in 1, `req_ready` out 1, request handshake
- `req_is_store` in 1, `req_funct3` in 3, `req_addr` in ADDR_WIDTH (byte), `req_wdata` in DATA_WIDTH, `req_tag` in ROB_TAG_WIDTH
- `resp_valid` out 1, `resp_ready` in 1, response handshake
- `resp_tag` out ROB_TAG_WIDTH, `resp_data` out DATA_WIDTH, `resp_is_store` out 1, `resp_exception` out 1
- `mem_raddr` out ADDR_WIDTH, byte address
- `mem_waddr` out ADDR_WIDTH, word index (addr>>2, zero-extended)
- `mem_wdata` out DATA_WIDTH
- `mem_funct3` out 3
- `mem_read_en` out 1, `mem_write_en` out 1
- `mem_rdata` in DATA_WIDTH, `mem_rdata_valid` in 1

## Operation
- FSM states: IDLE, LD_REQ, LD_WAIT, RMW_RD, RMW_WAIT, ST_WR, RESP.
- `req_ready` = (state==IDLE); it is 0 in RESP until the response handshake completes.
- Load: IDLE→LD_REQ (`mem_read_en`=1, `mem_raddr`=req_addr, `mem_funct3`=req_funct3)→LD_WAIT→RESP on `mem_rdata_valid`. `resp_data` is `mem_rdata` unchanged; `Memory` performs extension.
- SW: IDLE→ST_WR (`mem_write_en`=1, `mem_wdata`=req_wdata)→RESP.
- SB/SH: IDLE→RMW_RD (`mem_read_en`=1, `mem_funct3`=LW, `mem_raddr`=addr&~3)→RMW_WAIT→ST_WR with the merged word. Merge: SB replaces byte addr[1:0]; SH replaces half addr[1].
- Store responses: `resp_data`=0, `resp_is_store`=1.
- Illegal funct3 (loads: 011/110/111; stores: ≥011): IDLE→RESP with `resp_exception`=1 and no memory enables.
- Misaligned accesses: see Configuration.
- `flush` during LD_REQ/LD_WAIT/RESP-of-load:
  - next state IDLE; `resp_valid` dropped; late `mem_rdata_valid` ignored.
  - Stores are issued only from commit, so `flush` has no effect in RMW_*/ST_WR/RESP-of-store.
- `flush` in the same cycle as `req_valid`: the request is not accepted.
- RESP holds all `resp_*` stable until `resp_ready`, then returns to IDLE.
- Reset values: state IDLE, every output 0 (`req_ready` 0 during reset, 1 the cycle after).

## Timing
- Accept cycle = cycle 0. All `mem_*` outputs and `resp_*` outputs are registered.
- Load: `mem_read_en` in cycle 1; `mem_rdata_valid` in cycle 2; `resp_valid` from cycle 3.
- SW: `mem_write_en` in cycle 1 (`Memory` writes at that cycle's negedge); `resp_valid` from cycle 2.
- SB/SH: read in cycle 1, data in cycle 2, write in cycle 3, `resp_valid` from cycle 4.
- Exception: `resp_valid` from cycle 1.
- `mem_read_en` and `mem_write_en` are each a single-cycle pulse and are never high together.
- Back-to-back throughput is one access per latency plus one cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0 → exception response in cycle 1, no memory access.
- Undefined:
  - no misalign check; address is aligned down to the access size and the access proceeds; `resp_exception` is set only for illegal funct3.

## Structure
- `parameter_pkg` holds:
  - funct3 constants LB/LH/LW/LBU/LHU and SB/SH/SW
  - `lsu_state_t` enum
- Sub-module `lsu_store_merge`: combinational; inputs old word, new data, funct3, addr[1:0]; output merged word.

## Test plan
- SW addr 0x10, data 0xDEADBEEF → cycle 1: `mem_write_en`=1, `mem_waddr`=4, `mem_wdata`=0xDEADBEEF; cycle 2: `resp_valid`, `resp_is_store`=1.
- Word 4 = 0x80FF1234; LB addr 0x13 → cycle 1: `mem_raddr`=0x13, `mem_funct3`=000; cycle 3: `resp_data`=0xFFFFFF80, correct tag.
- Word 4 = 0x80FF1234; SB addr 0x11, data 0xAB → read cycle 1 (raddr 0x10, LW); write cycle 3 with 0x80FFAB34; `resp_valid` cycle 4.
- With macro defined, LW addr 0x12 → `resp_exception`=1 in cycle 1, no enables pulse. Without macro → reads word 4.
- LB accepted, `flush` in cycle 2 → no `resp_valid`, `req_ready`=1 in cycle 3. `flush` during SH → store completes, response delivered.
- `resp_ready` low for 3 cycles after a load → `resp_*` stable, `req_ready`=0; IDLE the cycle after the handshake.

Source files
------------

// File: rtl/parameter_pkg.sv
// parameter_pkg: funct3 encodings, LSU state type and access-size helpers
package parameter_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, RMW_RD, RMW_WAIT, ST_WR, RESP
  } lsu_state_t;
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    return is_store ? (f3 < 3'd3) : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
  endfunction
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_store_merge.sv
// lsu_store_merge: splices a byte or halfword store into the old memory word
module lsu_store_merge
  import parameter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] merged
);
  // replace the addressed lane, keep the rest of the old word
  always_comb begin
    merged = old_word;
    if (funct3 == F3_SB) merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
    else if (funct3 == F3_SH) merged[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
    else merged = new_data;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: one-at-a-time load/store port with RMW for SB/SH; LSU_MISALIGN_TRAP_EN enables misalign traps
module lsu_mem_port
  import parameter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int ROB_TAG_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [ROB_TAG_WIDTH-1:0] req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ROB_TAG_WIDTH-1:0] resp_tag,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_is_store,
  output logic                     resp_exception,
  output logic [ADDR_WIDTH-1:0]    mem_raddr,
  output logic [ADDR_WIDTH-1:0]    mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [2:0]               mem_funct3,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_rdata_valid
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("lsu_mem_port: DEPTH must be positive");
  end
  lsu_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] merged;
  logic [ADDR_WIDTH-1:0] aligned;
  logic                  bad;
  logic                  kill;
  assign req_ready = state == IDLE && !rst;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = !f3_legal(req_is_store, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
`else
  assign bad = !f3_legal(req_is_store, req_funct3);
`endif
  assign aligned = req_funct3[1:0] == 2'b10 ? {req_addr[ADDR_WIDTH-1:2], 2'b00} :
                   req_funct3[1:0] == 2'b01 ? {req_addr[ADDR_WIDTH-1:1], 1'b0} : req_addr;
  // loads are speculative: flush drops them anywhere up to and including their response
  assign kill = flush && !resp_is_store && (state == LD_REQ || state == LD_WAIT || state == RESP);
  lsu_store_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word(mem_rdata),
    .new_data(wdata_q),
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .merged  (merged)
  );
  // access sequencer; every memory and response output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      f3_q           <= '0;
      resp_valid     <= 1'b0;
      resp_tag       <= '0;
      resp_data      <= '0;
      resp_is_store  <= 1'b0;
      resp_exception <= 1'b0;
      mem_raddr      <= '0;
      mem_waddr      <= '0;
      mem_wdata      <= '0;
      mem_funct3     <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      if (kill) begin
        state      <= IDLE;
        resp_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (req_valid && !flush) begin
            resp_tag       <= req_tag;
            resp_is_store  <= req_is_store;
            resp_exception <= bad;
            resp_data      <= '0;
            addr_q         <= aligned;
            wdata_q        <= req_wdata;
            f3_q           <= req_funct3;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (!req_is_store) begin
              state       <= LD_REQ;
              mem_read_en <= 1'b1;
              mem_raddr   <= aligned;
              mem_funct3  <= req_funct3;
            end else if (req_funct3 == F3_SW) begin
              state        <= ST_WR;
              mem_write_en <= 1'b1;
              mem_waddr    <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
              mem_wdata    <= req_wdata;
              mem_funct3   <= F3_SW;
            end else begin
              state       <= RMW_RD;
              mem_read_en <= 1'b1;
              mem_raddr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_funct3  <= F3_LW;
            end
          end
          LD_REQ: state <= LD_WAIT;
          LD_WAIT: if (mem_rdata_valid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= mem_rdata;
          end
          RMW_RD: state <= RMW_WAIT;
          RMW_WAIT: if (mem_rdata_valid) begin
            state        <= ST_WR;
            mem_write_en <= 1'b1;
            mem_waddr    <= {2'b00, addr_q[ADDR_WIDTH-1:2]};
            mem_wdata    <= merged;
            mem_funct3   <= f3_q;
          end
          ST_WR: begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
          RESP: if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
